// File: rtl/poly_bank_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | poly_bank_loader_pkg : shared Kyber parameters and loader state encoding.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package poly_bank_loader_pkg;

   localparam int KYBER_N   = 256;
   localparam int KYBER_Q   = 3329;
   localparam int NUM_SLOTS = 5;
   localparam int COEFF_W   = 16;
   // Cycles from an accepted beat until its coefficient is visible on poly_out.
   localparam int DELAY     = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/poly_bank_loader_cond_sub_q.sv
// +----------------------------------------------------------------------------+
// | cond_sub_q : single conditional subtraction of q with out-of-range flag.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cond_sub_q
   import poly_bank_loader_pkg::*;
#(
   parameter int CW = COEFF_W,
   parameter int Q  = KYBER_Q
) (
   input  logic [CW-1:0] coeff_in,
   output logic [CW-1:0] coeff_out,
   output logic          out_of_range
);

   localparam logic [CW-1:0] Q_C     = CW'(Q);
   localparam logic [CW-1:0] TWO_Q_C = CW'(2 * Q);

   // Inputs at or above 2q cannot be brought into range by one subtraction.
   always_comb begin
      coeff_out    = (coeff_in >= Q_C) ? (coeff_in - Q_C) : coeff_in;
      out_of_range = (coeff_in >= TWO_Q_C);
   end

endmodule

`default_nettype wire

// File: rtl/poly_bank_loader.sv
// +----------------------------------------------------------------------------+
// | poly_bank_loader : streams coefficients into one of several polynomial     |
// | slots with conditional reduction mod q.                Revision: 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module poly_bank_loader
   import poly_bank_loader_pkg::*;
#(
   parameter int N     = KYBER_N,
   parameter int Q     = KYBER_Q,
   parameter int SLOTS = NUM_SLOTS,
   parameter int CW    = COEFF_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0]          slot,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CW-1:0]       in_coeff,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [SLOTS-1:0]    slot_full,
   output logic [N*CW-1:0]     poly_out [0:SLOTS-1]
);

   localparam int IW = $clog2(N);
   localparam logic [2:0]    LAST_SLOT = 3'(SLOTS - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [2:0]          slot_q, slot_d;
   logic                err_q, err_d;
   logic [SLOTS-1:0]    full_q, full_d;
   logic [N*CW-1:0]     poly_q [0:SLOTS-1];
   logic [N*CW-1:0]     poly_d [0:SLOTS-1];

   logic [CW-1:0]       red_coeff;
   logic                red_oor;

   cond_sub_q #(
      .CW (CW),
      .Q  (Q)
   ) u_cond_sub_q (
      .coeff_in     (in_coeff),
      .coeff_out    (red_coeff),
      .out_of_range (red_oor)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      slot_d  = slot_q;
      err_d   = err_q;
      full_d  = full_q;
      poly_d  = poly_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (slot <= LAST_SLOT) begin
                  slot_d       = slot;
                  full_d[slot] = 1'b0;
                  err_d        = 1'b0;
                  idx_d        = '0;
                  state_d      = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (in_valid) begin
               poly_d[slot_q][idx_q*CW +: CW] = red_coeff;
               if (red_oor) begin
                  err_d = 1'b1;
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  full_d[slot_q] = 1'b1;
                  state_d        = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         slot_q  <= '0;
         err_q   <= 1'b0;
         full_q  <= '0;
         poly_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         slot_q  <= slot_d;
         err_q   <= err_d;
         full_q  <= full_d;
         poly_q  <= poly_d;
      end
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign busy      = (state_q == ST_LOAD);
   assign done      = (state_q == ST_DONE);
   assign err       = err_q;
   assign slot_full = full_q;
   assign poly_out  = poly_q;

endmodule

`default_nettype wire

// File: tb/tb_poly_bank_loader.sv
// +----------------------------------------------------------------------------+
// | tb_poly_bank_loader : randomized directed bench with a reference model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_poly_bank_loader;

   localparam int N     = 256;
   localparam int Q     = 3329;
   localparam int SLOTS = 5;
   localparam int CW    = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic [2:0]          slot;
   logic                in_valid;
   logic                in_ready;
   logic [CW-1:0]       in_coeff;
   logic                busy;
   logic                done;
   logic                err;
   logic [SLOTS-1:0]    slot_full;
   logic [N*CW-1:0]     poly_out [0:SLOTS-1];

   always #5 clk = ~clk;

   poly_bank_loader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .slot      (slot),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_coeff  (in_coeff),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .slot_full (slot_full),
      .poly_out  (poly_out)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [CW-1:0]    ref_poly [SLOTS][N];
   logic [SLOTS-1:0] ref_full;
   logic             ref_err;
   int               src [N];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] reduce(input int c);
      if (c < Q) return CW'(c);
      return CW'(c - Q);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_slot(input string tag, input int s, input logic [N*CW-1:0] bus);
      logic [N*CW-1:0] exp_bus;
      int bad = -1;
      for (int i = 0; i < N; i++) begin
         exp_bus[i*CW +: CW] = ref_poly[s][i];
         if (bad < 0 && bus[i*CW +: CW] !== ref_poly[s][i]) bad = i;
      end
      if (bad < 0) bad = 0;
      vectors++;
      assert (bus === exp_bus) else begin
         miscompares++;
         $error("FAIL %s slot %0d coeff %0d: observed %0d, expected %0d",
                tag, s, bad, bus[bad*CW +: CW], exp_bus[bad*CW +: CW]);
      end
   endtask

   task automatic check_all_slots(input string tag);
      for (int s = 0; s < SLOTS; s++) chk_slot(tag, s, poly_out[s]);
   endtask

   task automatic model_reset();
      for (int s = 0; s < SLOTS; s++)
         for (int i = 0; i < N; i++) ref_poly[s][i] = '0;
      ref_full = '0;
      ref_err  = 1'b0;
   endtask

   // Runs one load of slot s from src[]; abort_at >= 0 asserts rst at that beat.
   task automatic do_load(input int s, input int duty, input bit poke, input int abort_at);
      int k = 0;
      int cyc = 0;
      bit pending = 0;
      bit timed_out = 0;
      start = 1'b1;
      slot  = 3'(s);
      tick();
      start = 1'b0;
      cyc   = 1;
      ref_full[s] = 1'b0;
      ref_err     = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("err_cleared_by_start", err, ref_err);
      forever begin
         if (pending) begin
            chk("err_per_beat", err, ref_err);
            chk("coeff_visible", poly_out[s][(k-1)*CW +: CW], ref_poly[s][k-1]);
            if (!done) chk("slot_full_mid_load", slot_full, ref_full);
            pending = 0;
         end
         if (done) break;
         if (cyc > 4*N + 100) begin
            timed_out = 1;
            break;
         end
         if (k == abort_at) begin
            in_valid = 1'b1;
            in_coeff = CW'(src[k]);
            rst      = 1'b1;
            tick();
            rst      = 1'b0;
            in_valid = 1'b0;
            model_reset();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_slot_full", slot_full, 0);
            check_all_slots("after_rst");
            repeat (3) begin
               tick();
               chk("no_done_after_rst", done, 0);
            end
            return;
         end
         in_valid = (k < N) && ($urandom_range(0, 99) < duty);
         in_coeff = CW'(src[(k < N) ? k : 0]);
         if (poke) begin
            start = ($urandom_range(0, 7) == 0);
            slot  = 3'($urandom_range(0, 7));
         end
         if (in_valid && in_ready) begin
            ref_poly[s][k] = reduce(src[k]);
            if (src[k] >= 2*Q) ref_err = 1'b1;
            k++;
            pending = 1;
         end
         tick();
         cyc++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      slot     = 3'(s);
      chk("load_timeout", timed_out, 0);
      chk("accept_count", k, N);
      if (duty >= 100 && !poke) chk("done_cycle", cyc, N + 1);
      chk("done_busy", busy, 0);
      chk("done_in_ready", in_ready, 0);
      ref_full[s] = 1'b1;
      if (poke) begin
         start = 1'b1;
         slot  = 3'((s + 1) % SLOTS);
      end
      tick();
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("slot_full", slot_full, ref_full);
      chk("err_after_load", err, ref_err);
      check_all_slots("after_load");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      slot     = '0;
      in_valid = 1'b0;
      in_coeff = '0;
      model_reset();
      repeat (2) tick();
      rst = 1'b0;
      chk("reset_in_ready", in_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_slot_full", slot_full, 0);
      check_all_slots("reset");

      // Ramp into slot 2 with in_valid held high.
      for (int i = 0; i < N; i++) src[i] = i;
      do_load(2, 100, 0, -1);
      chk("slot2_full_only", slot_full, 5'b00100);

      // Reduction boundaries into slot 0.
      for (int i = 0; i < N; i++) src[i] = $urandom_range(0, Q - 1);
      src[0] = 3328;
      src[1] = 3329;
      src[2] = 6657;
      src[3] = 6658;
      do_load(0, 100, 0, -1);
      chk("bound_3328", poly_out[0][0*CW +: CW], 3328);
      chk("bound_3329", poly_out[0][1*CW +: CW], 0);
      chk("bound_6657", poly_out[0][2*CW +: CW], 3328);
      chk("bound_6658", poly_out[0][3*CW +: CW], 3329);
      chk("bound_err_sticky", err, 1);

      // Out-of-range slot indices in IDLE.
      for (int bad = 5; bad <= 7; bad += 2) begin
         start = 1'b1;
         slot  = 3'(bad);
         tick();
         start   = 1'b0;
         ref_err = 1'b1;
         chk("bad_slot_err", err, ref_err);
         chk("bad_slot_in_ready", in_ready, 0);
         chk("bad_slot_busy", busy, 0);
         chk("bad_slot_full", slot_full, ref_full);
      end
      check_all_slots("bad_slot");

      // Gappy stream into slot 4 with stray start pulses.
      for (int i = 0; i < N; i++) src[i] = $urandom_range(0, 65535);
      do_load(4, 50, 1, -1);

      // Reset in the middle of a slot 1 load, then a clean reload.
      for (int i = 0; i < N; i++) src[i] = $urandom_range(0, 2*Q - 1);
      do_load(1, 100, 0, 100);
      do_load(1, 80, 0, -1);

      // All five slots back to back, then select each through a 5-way mux.
      for (int s = 0; s < SLOTS; s++) begin
         for (int i = 0; i < N; i++) src[i] = $urandom_range(0, 2*Q - 1);
         do_load(s, 70, 0, -1);
      end
      chk("all_full", slot_full, 5'b11111);
      for (int sel = 0; sel < SLOTS; sel++) begin
         logic [N*CW-1:0] mux_out;
         mux_out = poly_out[sel];
         chk_slot("mux_sel", sel, mux_out);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
